capi_job_mmio_ctrl: RTL and testbench

CAPI_JOB_MMIO_CTRL -- requirements
Module: capi_job_mmio_ctrl

---
 rtl/capi_afu_pkg.sv | 29 ++
 rtl/capi_mmio_regfile.sv | 116 +++++++++++
 rtl/capi_job_mmio_ctrl.sv | 161 ++++++++++++++++
 tb/tb_capi_job_mmio_ctrl.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capi_afu_pkg.sv
// Shared definitions for the CAPI job/MMIO controller: job command codes,
// job FSM state encoding, AFU descriptor word 0 and ah_jerror bit positions.
// Optional feature macro used by this slice: CAPI_PARITY_CHECK_EN.
package capi_afu_pkg;

    localparam logic [7:0] JCOM_RESET = 8'h80;
    localparam logic [7:0] JCOM_START = 8'h90;

    // Descriptor word 0: 0 interrupts, 1 process, 1 AFU config record,
    // dedicated-process programming model.
    localparam logic [63:0] DESC0 = 64'h0000_0001_0001_8010;

    // ah_jerror bit positions, big-endian numbering (bit 0 is the MSB)
    localparam int JERR_JCOM_PAR   = 0;
    localparam int JERR_MMIO_PAR   = 1;
    localparam int JERR_START_BUSY = 62;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } job_state_e;

    // Odd parity bit for a 64-bit word
    function automatic logic odd_par64(input logic [0:63] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/capi_mmio_regfile.sv
// MMIO register file: register array, address decode, write handling,
// fixed-latency ack delay line and read data parity. Register 0 is the
// read-only status word supplied by the job controller.
// Optional feature macro: CAPI_PARITY_CHECK_EN (write parity checking).
module capi_mmio_regfile
    import capi_afu_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int MMIO_ACK_LAT = 1
) (
    input  logic                    ha_pclock,
    input  logic                    ha_preset_n,
    input  logic                    mmval_i,
    input  logic                    mmcfg_i,
    input  logic                    mmrnw_i,
    input  logic                    mmdw_i,
    input  logic [0:23]             mmad_i,
    input  logic                    mmadpar_i,
    input  logic [0:63]             mmdata_i,
    input  logic                    mmdatapar_i,
    input  logic                    clear_i,
    input  logic [0:63]             status_i,
    output logic                    mmack_o,
    output logic [0:63]             mmrdata_o,
    output logic                    mmrdatapar_o,
    output logic                    par_err_o,
    output logic [0:NUM_REGS*64-1]  reg_q_o
);

    localparam int         IDXW = $clog2(NUM_REGS);
    localparam logic [2:0] LAT  = 3'(MMIO_ACK_LAT);

    logic [0:63]     regs_q [NUM_REGS];
    logic [2:0]      ack_cnt_q;
    logic [0:63]     rdata_q;
    logic [IDXW-1:0] idx;
    logic            in_range;
    logic            accept;
    logic            wr_bad;
    logic            wr_go;
    logic [0:63]     dw_data;
    logic [0:63]     rd_data;

    // ha_mmad is a word address with bit 23 as LSB; bits above the index must be 0
    assign idx      = mmad_i[23-IDXW +: IDXW];
    assign in_range = (mmad_i[0:22-IDXW] == '0);

    // A new request is only taken once the previous one has been fully acked
    assign accept = mmval_i && (ack_cnt_q == 3'd0);

`ifdef CAPI_PARITY_CHECK_EN
    assign wr_bad = !mmrnw_i &&
                    ((^{mmad_i, mmadpar_i}) == 1'b0 || (^{mmdata_i, mmdatapar_i}) == 1'b0);
`else
    logic unused_par;
    assign unused_par = mmadpar_i ^ mmdatapar_i;
    assign wr_bad     = 1'b0;
`endif

    assign par_err_o = accept && wr_bad;
    assign wr_go     = accept && !mmrnw_i && !mmcfg_i && !wr_bad && in_range && (idx != '0);

    // Read data selection: descriptor space, status, register, then word replication
    always_comb begin
        dw_data = '0;
        if (mmcfg_i) begin
            if (mmad_i == '0) dw_data = DESC0;
        end else if (in_range) begin
            dw_data = (idx == '0) ? status_i : regs_q[idx];
        end
        rd_data = dw_data;
        if (!mmdw_i) begin
            if (mmad_i[23]) rd_data = {dw_data[32:63], dw_data[32:63]};
            else            rd_data = {dw_data[0:31], dw_data[0:31]};
        end
    end

    // Ack delay line: read data is captured at request time and held until the ack
    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            ack_cnt_q <= 3'd0;
            rdata_q   <= '0;
        end else if (accept) begin
            ack_cnt_q <= LAT;
            rdata_q   <= mmrnw_i ? rd_data : '0;
        end else if (ack_cnt_q != 3'd0) begin
            ack_cnt_q <= ack_cnt_q - 3'd1;
        end
    end

    assign mmack_o      = (ack_cnt_q == 3'd1);
    assign mmrdata_o    = mmack_o ? rdata_q : '0;
    assign mmrdatapar_o = odd_par64(mmrdata_o);

    // Register array; writes commit at request time so they are visible by the ack
    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_go) begin
            if (mmdw_i)          regs_q[idx]        <= mmdata_i;
            else if (mmad_i[23]) regs_q[idx][32:63] <= mmdata_i[32:63];
            else                 regs_q[idx][0:31]  <= mmdata_i[32:63];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        if (g == 0) begin : g_status
            assign reg_q_o[0:63] = status_i;
        end else begin : g_reg
            assign reg_q_o[g*64 +: 64] = regs_q[g];
        end
    end

endmodule

// File: rtl/capi_job_mmio_ctrl.sv
// CAPI AFU job controller with MMIO register file. Decodes job RESET/START,
// tracks the running job, counts completed jobs and reports sticky errors
// on ah_jdone.
// Optional feature macro: CAPI_PARITY_CHECK_EN (input parity checking).
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | no job; waiting for START
//   ST_RUNNING | job active, ah_jrunning=1, waiting for work_done
//   ST_DONE    | one-cycle ah_jdone pulse (job end or RESET complete)
module capi_job_mmio_ctrl
    import capi_afu_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int MMIO_ACK_LAT = 1
) (
    input  logic                   ha_pclock,
    input  logic                   ha_preset_n,
    input  logic                   ha_jval,
    input  logic [0:7]             ha_jcom,
    input  logic                   ha_jcompar,
    input  logic [0:63]            ha_jea,
    input  logic                   ha_jeapar,
    output logic                   ah_jrunning,
    output logic                   ah_jdone,
    output logic [0:63]            ah_jerror,
    output logic                   ah_paren,
    input  logic                   ha_mmval,
    input  logic                   ha_mmcfg,
    input  logic                   ha_mmrnw,
    input  logic                   ha_mmdw,
    input  logic [0:23]            ha_mmad,
    input  logic                   ha_mmadpar,
    input  logic [0:63]            ha_mmdata,
    input  logic                   ha_mmdatapar,
    output logic                   ah_mmack,
    output logic [0:63]            ah_mmdata,
    output logic                   ah_mmdatapar,
    output logic                   job_start,
    output logic [0:63]            job_ea,
    input  logic                   work_done,
    output logic [0:NUM_REGS*64-1] reg_q
);

    job_state_e  state_q, state_d;
    logic [0:63] err_q, err_d;
    logic [31:0] job_cnt_q, job_cnt_d;
    logic [0:63] job_ea_q, job_ea_d;
    logic        job_start_q, job_start_d;
    logic        clear_regs;
    logic        jpar_bad;
    logic        cmd_ok;
    logic        is_reset;
    logic        is_start;
    logic        mm_par_err;
    logic [0:63] status;

`ifdef CAPI_PARITY_CHECK_EN
    assign ah_paren = 1'b1;
    assign jpar_bad = ha_jval &&
                      ((^{ha_jcom, ha_jcompar}) == 1'b0 || (^{ha_jea, ha_jeapar}) == 1'b0);
`else
    logic unused_jpar;
    assign unused_jpar = ha_jcompar ^ ha_jeapar;
    assign ah_paren    = 1'b0;
    assign jpar_bad    = 1'b0;
`endif

    assign cmd_ok   = ha_jval && !jpar_bad;
    assign is_reset = cmd_ok && (ha_jcom == JCOM_RESET);
    assign is_start = cmd_ok && (ha_jcom == JCOM_START);

    // Job state, error, counter and latched EA registers
    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            state_q     <= ST_IDLE;
            err_q       <= '0;
            job_cnt_q   <= '0;
            job_ea_q    <= '0;
            job_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            job_cnt_q   <= job_cnt_d;
            job_ea_q    <= job_ea_d;
            job_start_q <= job_start_d;
        end
    end

    // Next-state logic; RESET wins over everything, including work_done
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        job_cnt_d   = job_cnt_q;
        job_ea_d    = job_ea_q;
        job_start_d = 1'b0;
        clear_regs  = 1'b0;

        // Errors were just reported on the DONE pulse; start afresh
        if (state_q == ST_DONE) err_d = '0;
        if (mm_par_err)         err_d[JERR_MMIO_PAR] = 1'b1;
        if (jpar_bad)           err_d[JERR_JCOM_PAR] = 1'b1;

        if (is_reset) begin
            clear_regs = 1'b1;
            job_cnt_d  = '0;
            err_d      = '0;
            state_d    = ST_DONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_start) begin
                        job_ea_d    = ha_jea;
                        job_start_d = 1'b1;
                        state_d     = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (is_start) err_d[JERR_START_BUSY] = 1'b1;
                    if (work_done) begin
                        job_cnt_d = job_cnt_q + 32'd1;
                        state_d   = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ah_jrunning = (state_q == ST_RUNNING);
    assign ah_jdone    = (state_q == ST_DONE);
    assign ah_jerror   = (state_q == ST_DONE) ? err_q : '0;
    assign job_start   = job_start_q;
    assign job_ea      = job_ea_q;
    assign status      = {job_cnt_q, 31'd0, ah_jrunning};

    capi_mmio_regfile #(
        .NUM_REGS     (NUM_REGS),
        .MMIO_ACK_LAT (MMIO_ACK_LAT)
    ) u_regfile (
        .ha_pclock    (ha_pclock),
        .ha_preset_n  (ha_preset_n),
        .mmval_i      (ha_mmval),
        .mmcfg_i      (ha_mmcfg),
        .mmrnw_i      (ha_mmrnw),
        .mmdw_i       (ha_mmdw),
        .mmad_i       (ha_mmad),
        .mmadpar_i    (ha_mmadpar),
        .mmdata_i     (ha_mmdata),
        .mmdatapar_i  (ha_mmdatapar),
        .clear_i      (clear_regs),
        .status_i     (status),
        .mmack_o      (ah_mmack),
        .mmrdata_o    (ah_mmdata),
        .mmrdatapar_o (ah_mmdatapar),
        .par_err_o    (mm_par_err),
        .reg_q_o      (reg_q)
    );

endmodule

// File: tb/tb_capi_job_mmio_ctrl.sv
// Self-checking bench for capi_job_mmio_ctrl against a behavioural model
// of the job protocol and the MMIO register map.
`timescale 1ns/1ps
module tb_capi_job_mmio_ctrl;
    import capi_afu_pkg::*;

    localparam int NUM_REGS = 8;
    localparam int LAT      = 1;
`ifdef CAPI_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   ha_jval, ha_jcompar, ha_jeapar;
    logic [0:7]             ha_jcom;
    logic [0:63]            ha_jea;
    logic                   ah_jrunning, ah_jdone, ah_paren;
    logic [0:63]            ah_jerror;
    logic                   ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmadpar, ha_mmdatapar;
    logic [0:23]            ha_mmad;
    logic [0:63]            ha_mmdata;
    logic                   ah_mmack, ah_mmdatapar;
    logic [0:63]            ah_mmdata;
    logic                   job_start, work_done;
    logic [0:63]            job_ea;
    logic [0:NUM_REGS*64-1] reg_q;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [63:0] m_regs [NUM_REGS];
    logic [31:0] m_cnt;
    logic        m_running;

    always #5 clk = ~clk;

    capi_job_mmio_ctrl #(.NUM_REGS(NUM_REGS), .MMIO_ACK_LAT(LAT)) dut (
        .ha_pclock(clk), .ha_preset_n(rst_n),
        .ha_jval(ha_jval), .ha_jcom(ha_jcom), .ha_jcompar(ha_jcompar),
        .ha_jea(ha_jea), .ha_jeapar(ha_jeapar),
        .ah_jrunning(ah_jrunning), .ah_jdone(ah_jdone), .ah_jerror(ah_jerror), .ah_paren(ah_paren),
        .ha_mmval(ha_mmval), .ha_mmcfg(ha_mmcfg), .ha_mmrnw(ha_mmrnw), .ha_mmdw(ha_mmdw),
        .ha_mmad(ha_mmad), .ha_mmadpar(ha_mmadpar), .ha_mmdata(ha_mmdata), .ha_mmdatapar(ha_mmdatapar),
        .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata), .ah_mmdatapar(ah_mmdatapar),
        .job_start(job_start), .job_ea(job_ea), .work_done(work_done), .reg_q(reg_q)
    );

    function automatic logic op(input logic [63:0] v);
        return ~(^v);
    endfunction

    function automatic logic [63:0] m_status();
        return {m_cnt, 32'd0} + {63'd0, m_running};
    endfunction

    function automatic logic [63:0] m_read(input logic cfg, input logic dw, input logic [23:0] ad);
        logic [63:0] d;
        int r;
        d = 64'd0;
        r = int'(ad / 24'd2);
        if (cfg) d = (ad == 24'd0) ? DESC0 : 64'd0;
        else if (r < NUM_REGS) d = (r == 0) ? m_status() : m_regs[r];
        if (dw) return d;
        if (ad % 24'd2 == 24'd1) return {d[31:0], d[31:0]};
        return {d[63:32], d[63:32]};
    endfunction

    function automatic void m_write(input logic cfg, input logic dw, input logic [23:0] ad,
                                    input logic [63:0] wd, input logic bad);
        int r;
        r = int'(ad / 24'd2);
        if (cfg || (bad && PAR_EN) || r == 0 || r >= NUM_REGS) return;
        if (dw) m_regs[r] = wd;
        else if (ad % 24'd2 == 24'd1) m_regs[r][31:0] = wd[31:0];
        else m_regs[r][63:32] = wd[31:0];
    endfunction

    function automatic logic [0:NUM_REGS*64-1] m_flat();
        logic [0:NUM_REGS*64-1] f;
        f = '0;
        f[0:63] = m_status();
        for (int r = 1; r < NUM_REGS; r++) f[r*64 +: 64] = m_regs[r];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ha_jval = 0; ha_jcom = 8'h00; ha_jcompar = 1; ha_jea = '0; ha_jeapar = 1;
        ha_mmval = 0; ha_mmcfg = 0; ha_mmrnw = 0; ha_mmdw = 0; ha_mmad = '0; ha_mmadpar = 1;
        ha_mmdata = '0; ha_mmdatapar = 1; work_done = 0;
    endtask

    task automatic job_cmd(input logic [7:0] com, input logic [63:0] ea, input logic wd, input logic bad);
        ha_jval = 1; ha_jcom = com; ha_jcompar = op({56'd0, com}) ^ bad;
        ha_jea = ea; ha_jeapar = op(ea); work_done = wd;
        tick();
        ha_jval = 0; work_done = 0;
    endtask

    task automatic pulse_work_done();
        work_done = 1;
        tick();
        work_done = 0;
    endtask

    // One MMIO transaction; returns data/parity at the ack, latency (0 = timeout)
    // and the ack level one cycle after the ack.
    task automatic mmio(input logic rnw, input logic dw, input logic cfg, input logic [23:0] ad,
                        input logic [63:0] wd, input logic bad,
                        output logic [63:0] rd, output logic rpar, output int lat, output logic ack2);
        logic got;
        ha_mmval = 1; ha_mmcfg = cfg; ha_mmrnw = rnw; ha_mmdw = dw; ha_mmad = ad;
        ha_mmadpar = op({40'd0, ad}); ha_mmdata = wd; ha_mmdatapar = op(wd) ^ bad;
        tick();
        ha_mmval = 0;
        lat = 0; rd = '0; rpar = 0; got = 0;
        for (int i = 1; i <= 10; i++) begin
            if (!got) begin
                if (ah_mmack) begin
                    got = 1; lat = i; rd = ah_mmdata; rpar = ah_mmdatapar;
                end else begin
                    tick();
                end
            end
        end
        tick();
        ack2 = ah_mmack;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        ha_jval = 1; ha_jcom = JCOM_START; ha_mmval = 1; ha_mmrnw = 1; work_done = 1;
        repeat (3) tick();
        tests_run++;
        if ({ah_jrunning, ah_jdone, ah_mmack, job_start} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000", {ah_jrunning, ah_jdone, ah_mmack, job_start});
        end
        tests_run++;
        if (ah_jerror !== 64'd0 || job_ea !== 64'd0 || ah_mmdata !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_words: jerror=%h job_ea=%h mmdata=%h expected all 0", ah_jerror, job_ea, ah_mmdata);
        end
        tests_run++;
        if (ah_mmdatapar !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mmdatapar: got %b expected 1", ah_mmdatapar);
        end
        tests_run++;
        if (reg_q !== '0) begin
            tests_failed++;
            $display("FAIL reset_reg_q: got nonzero expected 0");
        end
        idle_inputs();
        rst_n = 1;
        for (int r = 0; r < NUM_REGS; r++) m_regs[r] = 64'd0;
        m_cnt = 0; m_running = 0;
        tick();
        tests_run++;
        if (ah_paren !== PAR_EN) begin
            tests_failed++;
            $display("FAIL paren: got %b expected %b", ah_paren, PAR_EN);
        end
    endtask

    task automatic test_job_start();
        job_cmd(JCOM_START, 64'h1000, 0, 0);
        m_running = 1;
        tests_run++;
        if (ah_jrunning !== 1'b1 || job_start !== 1'b1 || job_ea !== 64'h1000) begin
            tests_failed++;
            $display("FAIL job_start: running=%b start=%b ea=%h expected 1 1 1000", ah_jrunning, job_start, job_ea);
        end
        tick();
        tests_run++;
        if (job_start !== 1'b0 || ah_jrunning !== 1'b1) begin
            tests_failed++;
            $display("FAIL job_start_pulse: start=%b running=%b expected 0 1", job_start, ah_jrunning);
        end
    endtask

    task automatic test_job_done();
        logic [63:0] rd; logic rp, a2; int lat;
        pulse_work_done();
        m_running = 0; m_cnt++;
        tests_run++;
        if (ah_jdone !== 1'b1 || ah_jerror !== 64'd0 || ah_jrunning !== 1'b0) begin
            tests_failed++;
            $display("FAIL job_done: done=%b err=%h running=%b expected 1 0 0", ah_jdone, ah_jerror, ah_jrunning);
        end
        tick();
        tests_run++;
        if (ah_jdone !== 1'b0) begin
            tests_failed++;
            $display("FAIL job_done_pulse: done=%b expected 0", ah_jdone);
        end
        mmio(1, 1, 0, 24'h0, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== m_read(0, 1, 24'h0) || lat !== LAT) begin
            tests_failed++;
            $display("FAIL status_read: data=%h lat=%0d expected %h lat %0d", rd, lat, m_read(0, 1, 24'h0), LAT);
        end
    endtask

    task automatic test_mmio_basic();
        logic [63:0] rd; logic rp, a2; int lat;
        mmio(0, 1, 0, 24'h4, 64'hDEAD_BEEF_0123_4567, 0, rd, rp, lat, a2);
        m_write(0, 1, 24'h4, 64'hDEAD_BEEF_0123_4567, 0);
        tests_run++;
        if (lat !== LAT || a2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL dw_write_ack: lat=%0d ack_after=%b expected %0d 0", lat, a2, LAT);
        end
        tests_run++;
        if (reg_q !== m_flat()) begin
            tests_failed++;
            $display("FAIL dw_write_reg2: got %h expected %h", reg_q[128 +: 64], m_regs[2]);
        end
        mmio(1, 0, 0, 24'h5, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== m_read(0, 0, 24'h5) || lat !== LAT || rp !== op(rd)) begin
            tests_failed++;
            $display("FAIL word_read_lo: data=%h lat=%0d par=%b expected %h lat %0d", rd, lat, rp, m_read(0, 0, 24'h5), LAT);
        end
        mmio(1, 0, 0, 24'h4, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== m_read(0, 0, 24'h4) || rp !== op(rd)) begin
            tests_failed++;
            $display("FAIL word_read_hi: data=%h par=%b expected %h", rd, rp, m_read(0, 0, 24'h4));
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd; logic rp, a2; int lat;
        logic [23:0] ad;
        ad = 24'(NUM_REGS * 2);
        mmio(1, 1, 0, ad, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== 64'd0 || lat !== LAT || rp !== 1'b1) begin
            tests_failed++;
            $display("FAIL oob_read: data=%h lat=%0d par=%b expected 0 lat %0d par 1", rd, lat, rp, LAT);
        end
        mmio(0, 1, 0, ad, 64'hFFFF_0000_FFFF_0000, 0, rd, rp, lat, a2);
        mmio(0, 1, 0, 24'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, rp, lat, a2);
        tests_run++;
        if (reg_q !== m_flat() || lat !== LAT) begin
            tests_failed++;
            $display("FAIL oob_ro_write: reg_q changed or lat=%0d expected unchanged lat %0d", lat, LAT);
        end
    endtask

    task automatic test_cfg();
        logic [63:0] rd; logic rp, a2; int lat;
        mmio(1, 1, 1, 24'h0, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== DESC0 || lat !== LAT) begin
            tests_failed++;
            $display("FAIL cfg_desc0: data=%h lat=%0d expected %h lat %0d", rd, lat, DESC0, LAT);
        end
        mmio(1, 1, 1, 24'h4, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== 64'd0) begin
            tests_failed++;
            $display("FAIL cfg_other: data=%h expected 0", rd);
        end
        mmio(0, 1, 1, 24'h4, 64'h1234_5678_9ABC_DEF0, 0, rd, rp, lat, a2);
        tests_run++;
        if (reg_q !== m_flat() || lat !== LAT) begin
            tests_failed++;
            $display("FAIL cfg_write: reg_q changed or lat=%0d expected unchanged lat %0d", lat, LAT);
        end
    endtask

    task automatic test_pending();
        int acks;
        ha_mmval = 1; ha_mmcfg = 0; ha_mmrnw = 0; ha_mmdw = 1; ha_mmad = 24'h2;
        ha_mmadpar = op(64'h2); ha_mmdata = 64'hAAAA_5555_AAAA_5555; ha_mmdatapar = op(64'hAAAA_5555_AAAA_5555);
        tick();
        acks = int'(ah_mmack);
        ha_mmdata = 64'h1111_2222_3333_4444; ha_mmdatapar = op(64'h1111_2222_3333_4444);
        tick();
        ha_mmval = 0;
        acks += int'(ah_mmack);
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(ah_mmack);
        end
        m_write(0, 1, 24'h2, 64'hAAAA_5555_AAAA_5555, 0);
        tests_run++;
        if (acks !== 1 || reg_q !== m_flat()) begin
            tests_failed++;
            $display("FAIL pending_ignore: acks=%0d reg1=%h expected 1 ack reg1 %h", acks, reg_q[64 +: 64], m_regs[1]);
        end
    endtask

    task automatic test_start_busy();
        job_cmd(JCOM_START, 64'h2000, 0, 0);
        job_cmd(JCOM_START, 64'h3000, 0, 0);
        tests_run++;
        if (ah_jrunning !== 1'b1 || job_ea !== 64'h2000) begin
            tests_failed++;
            $display("FAIL start_busy_ignored: running=%b ea=%h expected 1 2000", ah_jrunning, job_ea);
        end
        pulse_work_done();
        m_cnt++;
        tests_run++;
        if (ah_jdone !== 1'b1 || ah_jerror !== 64'h2) begin
            tests_failed++;
            $display("FAIL start_busy_err: done=%b err=%h expected 1 0000000000000002", ah_jdone, ah_jerror);
        end
        tick();
        job_cmd(JCOM_START, 64'h4000, 0, 0);
        pulse_work_done();
        m_cnt++;
        tests_run++;
        if (ah_jdone !== 1'b1 || ah_jerror !== 64'd0) begin
            tests_failed++;
            $display("FAIL err_cleared: done=%b err=%h expected 1 0", ah_jdone, ah_jerror);
        end
        tick();
    endtask

    task automatic test_reset_override();
        logic [63:0] rd; logic rp, a2; int lat;
        mmio(0, 1, 0, 24'h6, 64'hCAFE_F00D_0000_0042, 0, rd, rp, lat, a2);
        m_write(0, 1, 24'h6, 64'hCAFE_F00D_0000_0042, 0);
        job_cmd(JCOM_START, 64'h5000, 0, 0);
        job_cmd(JCOM_RESET, 64'h0, 1, 0);
        m_running = 0; m_cnt = 0;
        for (int r = 1; r < NUM_REGS; r++) m_regs[r] = 64'd0;
        tests_run++;
        if (ah_jdone !== 1'b1 || ah_jerror !== 64'd0 || ah_jrunning !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cmd: done=%b err=%h running=%b expected 1 0 0", ah_jdone, ah_jerror, ah_jrunning);
        end
        tests_run++;
        if (reg_q !== m_flat()) begin
            tests_failed++;
            $display("FAIL reset_cmd_clear: reg3=%h status=%h expected cleared", reg_q[192 +: 64], reg_q[0:63]);
        end
        tick();
        mmio(1, 1, 0, 24'h0, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== 64'd0 || ah_jdone !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_cnt: status=%h done=%b expected 0 0", rd, ah_jdone);
        end
    endtask

    task automatic test_reset_mid_mmio();
        int acks;
        ha_mmval = 1; ha_mmcfg = 0; ha_mmrnw = 1; ha_mmdw = 1; ha_mmad = 24'h2; ha_mmadpar = op(64'h2);
        ha_jval = 1; ha_jcom = JCOM_RESET; ha_jcompar = op(64'h80); ha_jea = '0; ha_jeapar = 1;
        tick();
        ha_mmval = 0; ha_jval = 0;
        acks = int'(ah_mmack);
        tests_run++;
        if (ah_mmack !== 1'b1 || ah_jdone !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_mmio: ack=%b done=%b expected 1 1", ah_mmack, ah_jdone);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            acks += int'(ah_mmack);
        end
        tests_run++;
        if (acks !== 1) begin
            tests_failed++;
            $display("FAIL reset_mid_mmio_once: acks=%0d expected 1", acks);
        end
    endtask

    task automatic test_random_mmio();
        logic [63:0] rd, exp, wd; logic rp, a2, rnw, dw, cfg; int lat;
        logic [23:0] ad;
        for (int n = 0; n < 60; n++) begin
            rnw = 1'($urandom_range(0, 1));
            dw  = 1'($urandom_range(0, 1));
            cfg = ($urandom_range(0, 7) == 0);
            ad  = 24'($urandom_range(0, NUM_REGS * 2 + 3));
            wd  = {$urandom, $urandom};
            exp = m_read(cfg, dw, ad);
            mmio(rnw, dw, cfg, ad, wd, 0, rd, rp, lat, a2);
            if (rnw) begin
                tests_run++;
                if (rd !== exp || rp !== op(rd) || lat !== LAT || a2 !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_read ad=%h dw=%b cfg=%b: data=%h par=%b lat=%0d expected %h lat %0d",
                             ad, dw, cfg, rd, rp, lat, exp, LAT);
                end
            end else begin
                m_write(cfg, dw, ad, wd, 0);
                tests_run++;
                if (reg_q !== m_flat() || lat !== LAT) begin
                    tests_failed++;
                    $display("FAIL rand_write ad=%h dw=%b cfg=%b data=%h: lat=%0d or reg_q differs", ad, dw, cfg, wd, lat);
                end
            end
        end
    endtask

    task automatic test_random_jobs();
        logic [63:0] ea, rd; logic rp, a2; int k, lat;
        for (int n = 0; n < 8; n++) begin
            ea = {$urandom, $urandom};
            k  = int'($urandom_range(0, 2));
            job_cmd(JCOM_START, ea, 0, 0);
            for (int j = 0; j < k; j++) job_cmd(JCOM_START, {$urandom, $urandom}, 0, 0);
            tests_run++;
            if (ah_jrunning !== 1'b1 || job_ea !== ea) begin
                tests_failed++;
                $display("FAIL rand_job_run: running=%b ea=%h expected 1 %h", ah_jrunning, job_ea, ea);
            end
            pulse_work_done();
            m_cnt++;
            tests_run++;
            if (ah_jdone !== 1'b1 || ah_jerror !== ((k > 0) ? 64'h2 : 64'h0)) begin
                tests_failed++;
                $display("FAIL rand_job_done k=%0d: done=%b err=%h", k, ah_jdone, ah_jerror);
            end
            pulse_work_done();
        end
        mmio(1, 1, 0, 24'h0, 64'd0, 0, rd, rp, lat, a2);
        tests_run++;
        if (rd !== m_read(0, 1, 24'h0)) begin
            tests_failed++;
            $display("FAIL rand_job_count: status=%h expected %h", rd, m_read(0, 1, 24'h0));
        end
    endtask

    task automatic test_parity();
        logic [63:0] rd, exp_err; logic rp, a2; int lat;
        mmio(0, 1, 0, 24'h2, 64'h0BAD_0BAD_0BAD_0BAD, 1, rd, rp, lat, a2);
        m_write(0, 1, 24'h2, 64'h0BAD_0BAD_0BAD_0BAD, 1);
        tests_run++;
        if (lat !== LAT || reg_q !== m_flat()) begin
            tests_failed++;
            $display("FAIL par_write: lat=%0d reg1=%h expected lat %0d reg1 %h", lat, reg_q[64 +: 64], LAT, m_regs[1]);
        end
        job_cmd(JCOM_START, 64'h6000, 0, 1);
        tests_run++;
        if (ah_jrunning !== !PAR_EN) begin
            tests_failed++;
            $display("FAIL par_jcom: running=%b expected %b", ah_jrunning, !PAR_EN);
        end
        job_cmd(JCOM_START, 64'h7000, 0, 0);
        pulse_work_done();
        m_cnt++;
        exp_err = PAR_EN ? 64'hC000_0000_0000_0000 : 64'h2;
        tests_run++;
        if (ah_jdone !== 1'b1 || ah_jerror !== exp_err) begin
            tests_failed++;
            $display("FAIL par_jerror: done=%b err=%h expected 1 %h", ah_jdone, ah_jerror, exp_err);
        end
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_job_start();
        test_job_done();
        test_mmio_basic();
        test_out_of_range();
        test_cfg();
        test_pending();
        test_start_busy();
        test_reset_override();
        test_reset_mid_mmio();
        test_random_mmio();
        test_random_jobs();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
